// File: rtl/jstk_move_gen.sv
// Joystick move generator: debounces a sampled direction and issues one move per qualified deflection.
// Latency: move_valid rises 1 clk after the last qualifying tick. It is held until move_ready is seen.
// Backpressure: the pending move is frozen while move_ready=0. Optional auto-repeat is enabled by JSTK_AUTOREPEAT_EN.
module jstk_move_gen #(
  parameter int STABLE_TICKS = 4,
  parameter int REPEAT_TICKS = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [2:0] dir,
  input  logic       move_ready,
  output logic       move_valid,
  output logic [1:0] move_dir,
  output logic [7:0] move_count
);

  typedef enum logic [1:0] {IDLE, QUAL, ISSUE, HOLD} state_t;

  localparam logic [7:0] STABLE = 8'(STABLE_TICKS);

  state_t     state;
  logic [1:0] cand;
  logic [7:0] cnt;
  logic [7:0] cnt_inc;
  logic       is_move;

  // dir values 4..7 all mean neutral, so bit 2 alone separates moves from neutral
  assign is_move = ~dir[2];
  assign cnt_inc = cnt + 8'd1;

`ifdef JSTK_AUTOREPEAT_EN
  localparam logic [11:0] REPEAT = 12'(REPEAT_TICKS);
  logic [11:0] rpt;
  logic [11:0] rpt_inc;
  assign rpt_inc = rpt + 12'd1;
`endif

  // Qualification FSM with registered move outputs and accepted-move counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cand       <= 2'd0;
      cnt        <= 8'd0;
      move_valid <= 1'b0;
      move_dir   <= 2'd0;
      move_count <= 8'd0;
`ifdef JSTK_AUTOREPEAT_EN
      rpt        <= 12'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (tick && is_move) begin
            cand <= dir[1:0];
            cnt  <= 8'd1;
            if (STABLE == 8'd1) begin
              state      <= ISSUE;
              move_valid <= 1'b1;
              move_dir   <= dir[1:0];
            end else begin
              state <= QUAL;
            end
          end
        end

        QUAL: begin
          if (tick) begin
            if (!is_move) begin
              state <= IDLE;
              cnt   <= 8'd0;
            end else if (dir[1:0] == cand) begin
              cnt <= cnt_inc;
              if (cnt_inc == STABLE) begin
                state      <= ISSUE;
                move_valid <= 1'b1;
                move_dir   <= cand;
              end
            end else begin
              // a different deflection restarts qualification on the new direction
              cand <= dir[1:0];
              cnt  <= 8'd1;
            end
          end
        end

        ISSUE: begin
          // tick and dir are ignored here; only the handshake moves us on
          if (move_ready) begin
            state      <= HOLD;
            cnt        <= 8'd0;
            move_valid <= 1'b0;
            move_count <= move_count + 8'd1;
`ifdef JSTK_AUTOREPEAT_EN
            rpt        <= 12'd0;
`endif
          end
        end

        HOLD: begin
          if (tick) begin
            // re-arm only after neutral has been seen for STABLE consecutive ticks
            if (!is_move) begin
              if (cnt_inc == STABLE) begin
                state <= IDLE;
                cnt   <= 8'd0;
              end else begin
                cnt <= cnt_inc;
              end
            end else begin
              cnt <= 8'd0;
            end
`ifdef JSTK_AUTOREPEAT_EN
            // continued deflection in the same direction re-issues every REPEAT ticks
            if (is_move && (dir[1:0] == cand)) begin
              if (rpt_inc == REPEAT) begin
                state      <= ISSUE;
                move_valid <= 1'b1;
                move_dir   <= cand;
                rpt        <= 12'd0;
              end else begin
                rpt <= rpt_inc;
              end
            end else begin
              rpt <= 12'd0;
            end
`endif
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
